elelock_keyin: RTL and testbench

- Upstream front-end for the electronic-lock controller.
- Takes raw ten-key switch lines and synchronises and debounces them.
- Encodes each valid keypress into a BCD digit and collects CODE_LEN digits.
- Compares the collected digits against the stored code and issues a one-cycle unlock pulse (`key`) that the lock stage consumes directly.

---
 rtl/elelock_keyin_if.sv | 32 +++
 rtl/elelock_keyin.sv | 196 +++++++++++++++++++
 tb/tb_elelock_keyin.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/elelock_keyin_if.sv
// rtl/elelock_keyin_if.sv - key-entry front-end signal bundle
interface elelock_keyin_if;
   logic [9:0] tenkey;
   logic       close;
   logic       key;
   logic       err;
   logic       digit_valid;
   logic [3:0] digit;
   logic [3:0] count;

   // Side that drives the switches and the close request
   modport master (
      output tenkey,
      output close,
      input  key,
      input  err,
      input  digit_valid,
      input  digit,
      input  count
   );

   // Side that implements the key-entry front-end
   modport slave (
      input  tenkey,
      input  close,
      output key,
      output err,
      output digit_valid,
      output digit,
      output count
   );
endinterface

// File: rtl/elelock_keyin.sv
// rtl/elelock_keyin.sv - ten-key sync/debounce, BCD encode, code compare, unlock pulse
module elelock_keyin #(
   parameter int          CODE_LEN   = 4,
   parameter logic [31:0] CODE       = 32'h0000_1234,
   parameter int          DEB_CYCLES = 4,
   parameter int          TIMEOUT    = 1000
) (
   input  logic        clk,
   input  logic        reset,
   elelock_keyin_if.slave bus
);

   localparam int BUF_W = 4 * CODE_LEN;
   localparam int DW    = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES - 1) : 1;
   localparam int IW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   // Debounce counter saturates here; the stable vector follows the
   // candidate once the counter sits at this value with no change.
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 2);
   localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
   localparam logic [3:0]    FULL_CNT  = 4'(CODE_LEN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READY = 2'd1,
      HELD  = 2'd2
   } state_t;

   state_t            state, state_nxt;

   logic [10:0]       sync1, sync2;
   logic [9:0]        tk_s;
   logic              close_s;

   logic [9:0]        cand;
   logic [9:0]        stable;
   logic [DW-1:0]     deb_cnt;

   logic [BUF_W-1:0]  buffer;
   logic [BUF_W-1:0]  buf_nxt;
   logic [3:0]        cnt;
   logic [IW-1:0]     idle;

   logic              key_r, err_r, dv_r;
   logic [3:0]        digit_r;

   logic              onehot;
   logic [3:0]        enc;
   logic              accept;
   logic              full;
   logic              match;

   assign tk_s    = sync2[9:0];
   assign close_s = sync2[10];

   // Two-flop synchroniser shared by the ten switch lines and close
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {bus.close, bus.tenkey};
         sync2 <= sync1;
      end
   end

   // Debounce: any change reloads the candidate; a held candidate becomes stable
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cand    <= '0;
         deb_cnt <= '0;
         stable  <= '0;
      end else if (tk_s != cand) begin
         cand    <= tk_s;
         deb_cnt <= '0;
      end else if (deb_cnt != DEB_LAST) begin
         deb_cnt <= deb_cnt + 1'b1;
      end else begin
         stable  <= cand;
      end
   end

   // One-hot detection and bit-index encoding of the stable switch vector
   always_comb begin
      onehot = (stable != '0) && ((stable & (stable - 10'd1)) == '0);
      enc    = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (stable[i]) begin
            enc = 4'(i);
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state: one digit per press, chords are swallowed until release
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (stable == '0) begin
               state_nxt = READY;
            end
         end
         READY: begin
            if (stable != '0) begin
               state_nxt = HELD;
               accept    = onehot;
            end
         end
         HELD: begin
            if (stable == '0) begin
               state_nxt = READY;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // The first digit of an entry lands in the top nibble so that the last one
   // ends up in nibble 0, lining up with the stored code.
   always_comb begin
      buf_nxt = buffer;
      for (int i = 0; i < CODE_LEN; i++) begin
         if (i == CODE_LEN - 1 - int'(cnt)) begin
            buf_nxt[4*i +: 4] = enc;
         end
      end
      full  = (cnt == FULL_CNT);
      match = (buf_nxt == CODE[BUF_W-1:0]);
   end

   // Entry datapath: digit buffer, count, idle timeout and result pulses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buffer  <= '0;
         cnt     <= '0;
         idle    <= '0;
         key_r   <= 1'b0;
         err_r   <= 1'b0;
         dv_r    <= 1'b0;
         digit_r <= '0;
      end else begin
         dv_r  <= accept;
         key_r <= 1'b0;
         err_r <= 1'b0;
         if (accept) begin
            digit_r <= enc;
         end
         if (close_s) begin
            // close beats a coinciding final digit: no key, no err
            buffer <= '0;
            cnt    <= '0;
            idle   <= '0;
         end else if (accept) begin
            idle <= '0;
            if (full) begin
               key_r  <= match;
               err_r  <= !match;
               buffer <= '0;
               cnt    <= '0;
            end else begin
               buffer <= buf_nxt;
               cnt    <= cnt + 4'd1;
            end
         end else if (cnt != '0) begin
            if (idle == IDLE_LAST) begin
               buffer <= '0;
               cnt    <= '0;
               idle   <= '0;
            end else begin
               idle <= idle + 1'b1;
            end
         end else begin
            idle <= '0;
         end
      end
   end

   assign bus.key         = key_r;
   assign bus.err         = err_r;
   assign bus.digit_valid = dv_r;
   assign bus.digit       = digit_r;
   assign bus.count       = cnt;

endmodule

// File: tb/tb_elelock_keyin.sv
// tb/tb_elelock_keyin.sv - directed table-driven bench for elelock_keyin
module tb_elelock_keyin;

   logic clk;
   logic reset;

   elelock_keyin_if bus();

   elelock_keyin #(
      .CODE_LEN  (4),
      .CODE      (32'h0000_1234),
      .DEB_CYCLES(4),
      .TIMEOUT   (1000)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [9:0] pat;
      int         hold;
      int         exp_dv;
      logic [3:0] exp_digit;
      int         exp_key;
      int         exp_err;
      logic [3:0] exp_count;
   } vec_t;

   vec_t vq[$];

   int errors = 0;
   int checks = 0;
   int dv_n, key_n, err_n, both_n;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One cycle: wait for the falling edge and tally the pulse outputs
   task automatic tick();
      @(negedge clk);
      if (bus.digit_valid) dv_n++;
      if (bus.key) key_n++;
      if (bus.err) err_n++;
      if (bus.key && bus.err) both_n++;
   endtask

   task automatic clear_tallies();
      dv_n = 0; key_n = 0; err_n = 0;
   endtask

   task automatic press(input logic [9:0] pat, input int hold, input int gap);
      bus.tenkey = pat;
      repeat (hold) tick();
      bus.tenkey = '0;
      repeat (gap) tick();
   endtask

   task automatic enter4(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
      clear_tallies();
      press(10'(1) << a, 10, 12);
      press(10'(1) << b, 10, 12);
      press(10'(1) << c, 10, 12);
      press(10'(1) << d, 10, 12);
      check({tag, "_dv"}, dv_n, 4);
      check({tag, "_key"}, key_n, 1);
      check({tag, "_err"}, err_n, 0);
      check({tag, "_count"}, int'(bus.count), 0);
   endtask

   initial begin
      both_n     = 0;
      bus.tenkey = '0;
      bus.close  = 1'b0;
      reset      = 1'b1;
      clear_tallies();

      vq.push_back('{"d1",    10'b0000000010, 10, 1, 4'd1, 0, 0, 4'd1});
      vq.push_back('{"d2",    10'b0000000100, 10, 1, 4'd2, 0, 0, 4'd2});
      vq.push_back('{"d3",    10'b0000001000, 10, 1, 4'd3, 0, 0, 4'd3});
      vq.push_back('{"d4",    10'b0000010000, 10, 1, 4'd4, 1, 0, 4'd0});
      vq.push_back('{"glitch",10'b0001000000,  3, 0, 4'd4, 0, 0, 4'd0});
      vq.push_back('{"w1",    10'b0000000010, 10, 1, 4'd1, 0, 0, 4'd1});
      vq.push_back('{"w2",    10'b0000000100, 10, 1, 4'd2, 0, 0, 4'd2});
      vq.push_back('{"w3",    10'b0000001000, 10, 1, 4'd3, 0, 0, 4'd3});
      vq.push_back('{"w5",    10'b0000100000, 10, 1, 4'd5, 0, 1, 4'd0});
      vq.push_back('{"c7",    10'b0010000000, 10, 1, 4'd7, 0, 0, 4'd1});
      vq.push_back('{"chord", 10'b0000000110, 10, 0, 4'd7, 0, 0, 4'd1});
      vq.push_back('{"c0a",   10'b0000000001, 10, 1, 4'd0, 0, 0, 4'd2});
      vq.push_back('{"c0b",   10'b0000000001, 10, 1, 4'd0, 0, 0, 4'd3});
      vq.push_back('{"c8",    10'b0100000000, 10, 1, 4'd8, 0, 1, 4'd0});

      // Reset state
      #2;
      check("rst_key",   int'(bus.key), 0);
      check("rst_err",   int'(bus.err), 0);
      check("rst_dv",    int'(bus.digit_valid), 0);
      check("rst_digit", int'(bus.digit), 0);
      check("rst_count", int'(bus.count), 0);
      repeat (3) tick();
      reset = 1'b0;
      repeat (3) tick();

      // Latency: raw rise to digit_valid is seven clock edges
      clear_tallies();
      bus.tenkey = 10'b0000000010;
      repeat (6) tick();
      check("lat_dv_early", int'(bus.digit_valid), 0);
      tick();
      check("lat_dv_on", int'(bus.digit_valid), 1);
      check("lat_digit", int'(bus.digit), 1);
      tick();
      check("lat_dv_one_cycle", int'(bus.digit_valid), 0);
      repeat (2) tick();
      bus.tenkey = '0;
      repeat (12) tick();
      check("lat_count", int'(bus.count), 1);

      // Asynchronous reset mid-entry
      press(10'b0000000100, 10, 12);
      check("mid_count_pre", int'(bus.count), 2);
      reset = 1'b1;
      #1;
      check("mid_count", int'(bus.count), 0);
      check("mid_key",   int'(bus.key), 0);
      check("mid_err",   int'(bus.err), 0);
      tick();
      reset = 1'b0;
      repeat (3) tick();
      enter4("after_rst", 4'd1, 4'd2, 4'd3, 4'd4);

      // Table of single presses
      foreach (vq[i]) begin
         clear_tallies();
         press(vq[i].pat, vq[i].hold, 12);
         check($sformatf("%s_dv", vq[i].name),    dv_n, vq[i].exp_dv);
         check($sformatf("%s_digit", vq[i].name), int'(bus.digit), int'(vq[i].exp_digit));
         check($sformatf("%s_key", vq[i].name),   key_n, vq[i].exp_key);
         check($sformatf("%s_err", vq[i].name),   err_n, vq[i].exp_err);
         check($sformatf("%s_count", vq[i].name), int'(bus.count), int'(vq[i].exp_count));
      end

      // Bouncy key 5: toggles for three cycles then holds
      clear_tallies();
      bus.tenkey = 10'b0000100000; tick();
      bus.tenkey = '0;             tick();
      bus.tenkey = 10'b0000100000; tick();
      repeat (10) tick();
      bus.tenkey = '0;
      repeat (12) tick();
      check("bounce_dv",    dv_n, 1);
      check("bounce_digit", int'(bus.digit), 5);
      check("bounce_count", int'(bus.count), 1);

      // Timeout discards a partial entry without err
      reset = 1'b1; tick(); reset = 1'b0; repeat (3) tick();
      clear_tallies();
      press(10'b0000000010, 10, 12);
      press(10'b0000000100, 10, 12);
      repeat (900) tick();
      check("to_count_hold", int'(bus.count), 2);
      repeat (200) tick();
      check("to_count_clr", int'(bus.count), 0);
      check("to_err", err_n, 0);
      enter4("after_to", 4'd1, 4'd2, 4'd3, 4'd4);

      // close coincides with acceptance of the 4th correct digit
      clear_tallies();
      press(10'b0000000010, 10, 12);
      press(10'b0000000100, 10, 12);
      press(10'b0000001000, 10, 12);
      check("cl_count_pre", int'(bus.count), 3);
      bus.tenkey = 10'b0000010000;
      repeat (4) tick();
      bus.close = 1'b1;
      tick();
      bus.close = 1'b0;
      repeat (2) tick();
      check("cl_dv",    int'(bus.digit_valid), 1);
      check("cl_key",   int'(bus.key), 0);
      check("cl_err",   int'(bus.err), 0);
      check("cl_count", int'(bus.count), 0);
      repeat (3) tick();
      bus.tenkey = '0;
      repeat (12) tick();
      check("cl_key_total", key_n, 0);
      check("cl_err_total", err_n, 0);

      check("key_err_together", both_n, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
